// File: rtl/root_inverse_power_pkg.sv
// -----------------------------------------------------------------------------
// fixed_pkg: shared definitions for the Q10.10 exponentiation unit
// (root_inverse_power).
//   - Default operand, fraction and exponent widths.
//   - The constant 1.0 in Q10.10.
//   - The FSM state enum.
//   - Bit positions used to split a 2*WIDTH product into its result and
//     overflow slices.
// -----------------------------------------------------------------------------
package fixed_pkg;

  localparam int DEF_WIDTH = 20;
  localparam int DEF_FRAC  = 10;
  localparam int DEF_EXP_W = 3;

  // 1.0 in Q10.10
  localparam logic [DEF_WIDTH-1:0] ONE = 20'h00400;

  // Value reported when a product leaves the Q10.10 range (saturating build)
  localparam logic [DEF_WIDTH-1:0] SAT_VAL = 20'hFFFFF;

  // Slices of a 2*WIDTH Q20.20 product:
  //   [RES_MSB:RES_LSB] -> Q10.10 result (truncated)
  //   [OVF_MSB:OVF_LSB] -> integer bits that do not fit in Q10.10
  localparam int RES_LSB = DEF_FRAC;
  localparam int RES_MSB = DEF_WIDTH + DEF_FRAC - 1;
  localparam int OVF_LSB = DEF_WIDTH + DEF_FRAC;
  localparam int OVF_MSB = 2 * DEF_WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/root_inverse_power_if.sv
// -----------------------------------------------------------------------------
// root_inverse_power_if: operand/result framing of the exponentiation unit.
//
// Handshake:
//   - in_valid is a framing strobe, not a valid/ready pair. The unit registers
//     in_data_1/in_data_2 on every edge that samples in_valid=1 while it is idle
//     or loading, so the last beat wins.
//   - The first edge that samples in_valid=0 after such a burst starts the
//     computation.
//   - There is no ready signal. in_valid is ignored while a result is being
//     computed or presented.
//   - out_valid is a one-cycle strobe. out_data/out_ovf are zero whenever
//     out_valid is low.
//
// Signals:
//   in_valid   operand framing
//   in_data_1  base x, unsigned Q10.10
//   in_data_2  exponent n
//   out_valid  one-cycle result strobe
//   out_data   x^n, Q10.10
//   out_ovf    an intermediate product exceeded the Q10.10 range
//
// Modports:
//   master  drives the operands (producer side)
//   slave   the unit itself
// -----------------------------------------------------------------------------
interface root_inverse_power_if #(
  parameter int WIDTH = 20,
  parameter int EXP_W = 3
) ();

  logic             in_valid;
  logic [WIDTH-1:0] in_data_1;
  logic [EXP_W-1:0] in_data_2;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ovf;

  modport master (
    output in_valid, in_data_1, in_data_2,
    input  out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_data_1, in_data_2,
    output out_valid, out_data, out_ovf
  );

endinterface

// File: rtl/root_inverse_power_serial_mult.sv
// -----------------------------------------------------------------------------
// serial_mult: WIDTH x WIDTH unsigned shift-add multiplier, one multiplier bit
// per enabled cycle, LSB first.
//
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   i_start     load i_a (multiplicand) and i_b (multiplier), clear the product
//   i_en        consume one multiplier bit this edge
//   i_a, i_b    operands
//   o_done      high during the WIDTH-th enabled cycle after a start
//   o_prod      2*WIDTH product including the current bit
//
// o_prod is the running sum including the bit being consumed this cycle. When
// o_done is high, o_prod is the complete product in the same cycle. The caller
// can therefore restart on the very edge that finishes a multiply, and a chain
// of multiplies costs exactly WIDTH edges each.
//
// i_start has priority over i_en.
// -----------------------------------------------------------------------------
module serial_mult #(
  parameter int WIDTH = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic               i_en,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_prod
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_prod;
  logic [CNT_W-1:0]   r_cnt;

  logic [2*WIDTH-1:0] w_part;
  logic [2*WIDTH-1:0] w_sum;

  assign w_part = r_mplier[0] ? r_mcand : '0;
  assign w_sum  = r_prod + w_part;
  assign o_prod = w_sum;
  assign o_done = i_en && (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
    end else if (i_start) begin
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
      r_prod   <= '0;
      r_cnt    <= '0;
    end else if (i_en) begin
      r_prod   <= w_sum;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/root_inverse_power.sv
// -----------------------------------------------------------------------------
// root_inverse_power: sequential unsigned Q10.10 exponentiation, x^n for
// n = 0..7, by repeated serial shift-add multiplication.
//
// Ports:
//   clk          clock
//   rst_n        synchronous active-low reset; aborts any transaction in flight
//   bus          root_inverse_power_if.slave (in_valid/in_data_1/in_data_2 in,
//                out_valid/out_data/out_ovf out)
//   o_dbg_state  current FSM state
//
// Flow:
//   IDLE -> LOAD on in_valid. LOAD re-registers operands while in_valid=1.
//   The first edge with in_valid=0 (E0) sets acc=1.0 and starts the loop.
//   Each step is acc = trunc(acc * x) and takes WIDTH edges. The edge
//   completing the last step registers the result pulse. DONE clears it and
//   returns to IDLE.
//
// Build option ROOT_INVERSE_POWER_SATURATE_EN:
//   defined   - the first overflowing step ends the loop with
//               out_data=all ones, out_ovf=1
//   undefined - products wrap (truncated bits kept), all n steps run and
//               out_ovf is sticky
// -----------------------------------------------------------------------------
module root_inverse_power
  import fixed_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC,
  parameter int EXP_W = DEF_EXP_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  root_inverse_power_if.slave  bus,
  output state_e               o_dbg_state
);

  localparam logic [WIDTH-1:0] L_ONE = WIDTH'(1) << FRAC;

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_x, w_x_nxt;
  logic [EXP_W-1:0] r_n, w_n_nxt;
  logic [WIDTH-1:0] r_acc, w_acc_nxt;
  logic [EXP_W-1:0] r_iter, w_iter_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic [WIDTH-1:0] r_out_data, w_out_data_nxt;
  logic             r_out_ovf, w_out_ovf_nxt;

  logic               w_mult_start;
  logic               w_mult_en;
  logic [WIDTH-1:0]   w_mult_a;
  logic               w_mult_done;
  logic [2*WIDTH-1:0] w_prod;

  logic [WIDTH-1:0]   w_new_acc;
  logic               w_step_ovf;
  logic               w_ovf_acc;
  logic [EXP_W-1:0]   w_iter_dec;
  logic               w_unused_frac;

  // Multiplicand is the running acc, multiplier is the base x.
  serial_mult #(.WIDTH(WIDTH)) u_mult (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_mult_start),
    .i_en    (w_mult_en),
    .i_a     (w_mult_a),
    .i_b     (r_x),
    .o_done  (w_mult_done),
    .o_prod  (w_prod)
  );

  // Q20.20 product -> Q10.10: drop FRAC low bits (truncate). Anything above
  // the top WIDTH-FRAC integer bits is overflow.
  assign w_new_acc     = w_prod[FRAC +: WIDTH];
  assign w_step_ovf    = |w_prod[2*WIDTH-1 : WIDTH+FRAC];
  assign w_ovf_acc     = r_ovf | w_step_ovf;
  assign w_iter_dec    = r_iter - EXP_W'(1);
  assign w_unused_frac = ^w_prod[FRAC-1:0];

  always_comb begin
    w_state_nxt     = r_state;
    w_x_nxt         = r_x;
    w_n_nxt         = r_n;
    w_acc_nxt       = r_acc;
    w_iter_nxt      = r_iter;
    w_ovf_nxt       = r_ovf;
    // Result outputs are a one-cycle pulse: zero unless set below.
    w_out_valid_nxt = 1'b0;
    w_out_data_nxt  = '0;
    w_out_ovf_nxt   = 1'b0;
    w_mult_start    = 1'b0;
    w_mult_en       = 1'b0;
    w_mult_a        = r_acc;

    unique case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_x_nxt     = bus.in_data_1;
          w_n_nxt     = bus.in_data_2;
          w_state_nxt = LOAD;
        end
      end

      LOAD: begin
        if (bus.in_valid) begin
          w_x_nxt = bus.in_data_1;
          w_n_nxt = bus.in_data_2;
        end else begin
          w_acc_nxt  = L_ONE;
          w_iter_nxt = r_n;
          w_ovf_nxt  = 1'b0;
          if (r_n == '0) begin
            w_out_valid_nxt = 1'b1;
            w_out_data_nxt  = L_ONE;
            w_state_nxt     = DONE;
          end else begin
            w_mult_start = 1'b1;
            w_mult_a     = L_ONE;
            w_state_nxt  = MUL;
          end
        end
      end

      MUL: begin
        w_mult_en = 1'b1;
        if (w_mult_done) begin
          w_acc_nxt  = w_new_acc;
          w_iter_nxt = w_iter_dec;
          w_ovf_nxt  = w_ovf_acc;
`ifdef ROOT_INVERSE_POWER_SATURATE_EN
          if (w_step_ovf) begin
            w_out_valid_nxt = 1'b1;
            w_out_data_nxt  = '1;
            w_out_ovf_nxt   = 1'b1;
            w_state_nxt     = DONE;
          end else
`endif
          if (w_iter_dec == '0) begin
            w_out_valid_nxt = 1'b1;
            w_out_data_nxt  = w_new_acc;
            w_out_ovf_nxt   = w_ovf_acc;
            w_state_nxt     = DONE;
          end else begin
            // Next step starts on this same edge with the fresh acc.
            w_mult_start = 1'b1;
            w_mult_a     = w_new_acc;
          end
        end
      end

      DONE: begin
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_x         <= '0;
      r_n         <= '0;
      r_acc       <= '0;
      r_iter      <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_x         <= w_x_nxt;
      r_n         <= w_n_nxt;
      r_acc       <= w_acc_nxt;
      r_iter      <= w_iter_nxt;
      r_ovf       <= w_ovf_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_ovf   <= w_out_ovf_nxt;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_ovf   = r_out_ovf;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_root_inverse_power.sv
// -----------------------------------------------------------------------------
// tb_root_inverse_power: self-checking bench for root_inverse_power.
//
// Structure:
//   - A table of {x, n, expected data/ovf/latency} vectors drives the main
//     sweep.
//   - Hand-written sequences cover the multi-beat load, in_valid during MUL,
//     and reset mid-run.
//   - Expected results go to a queue when E0 is driven. The negedge monitor
//     pops and compares them on each out_valid pulse, including the exact
//     cycle of the pulse.
//
// Follows ROOT_INVERSE_POWER_SATURATE_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_root_inverse_power;
  import fixed_pkg::*;

  localparam int W  = 20;
  localparam int EW = 3;
  localparam int NV = 14;

  logic   clk   = 1'b0;
  logic   rst_n = 1'b0;
  state_e dbg_state;

  root_inverse_power_if #(.WIDTH(W), .EXP_W(EW)) bus ();

  root_inverse_power #(.WIDTH(W), .FRAC(10), .EXP_W(EW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no end, need end");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [W:0] exp_q[$];    // {ovf, data}
  int         cyc_q[$];    // cycle count at which the pulse must be seen
  int         n_cmp  = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic prev_v = 1'b0;
  logic [W:0] m_e;
  int         m_c;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid) begin
        check("pulse_width", 32'(prev_v), 32'd0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_pulse: got out_valid with data %h, expected none", bus.out_data);
        end else begin
          m_e = exp_q.pop_front();
          m_c = cyc_q.pop_front();
          check("out_data", 32'(bus.out_data), 32'(m_e[W-1:0]));
          check("out_ovf",  32'(bus.out_ovf),  32'(m_e[W]));
          check("latency_cycle", 32'(cyc), 32'(m_c));
        end
      end else begin
        check("idle_zero", {11'd0, bus.out_ovf, bus.out_data}, 32'd0);
      end
    end
    prev_v = bus.out_valid;
  end

  // ---------------- reference model ----------------
  function automatic logic [W:0] model(input logic [W-1:0] x, input int n, output int lat);
    logic [W-1:0]   acc;
    logic [2*W-1:0] p;
    logic           ovf;
    logic           so;
    acc = 20'h00400;
    ovf = 1'b0;
    lat = 20 * n;
    for (int i = 1; i <= n; i++) begin
      p   = {20'd0, acc} * {20'd0, x};
      so  = (p[39:30] != 10'd0);
      acc = p[29:10];
      ovf = ovf | so;
`ifdef ROOT_INVERSE_POWER_SATURATE_EN
      if (so) begin
        lat = 20 * i;
        return {1'b1, 20'hFFFFF};
      end
`endif
    end
    return {ovf, acc};
  endfunction

  // ---------------- driver tasks ----------------
  // Drive `beats` cycles of in_valid with the same operands, then drop it.
  // Returns e0 = cycle count after the E0 edge.
  task automatic send(input logic [W-1:0] x, input logic [EW-1:0] n, input int beats, output int e0);
    for (int b = 0; b < beats; b++) begin
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_data_1 = x;
      bus.in_data_2 = n;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    e0 = cyc + 1;
  endtask

  task automatic push_exp(input logic [W-1:0] d, input logic o, input int at_cyc);
    exp_q.push_back({o, d});
    cyc_q.push_back(at_cyc);
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout: got %0d results pending after %0d cycles, expected 0", exp_q.size(), budget);
      exp_q.delete();
      cyc_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [W-1:0]  x;
    logic [EW-1:0] n;
    logic [W-1:0]  exp_data;
    logic          exp_ovf;
    int            exp_lat;
  } vec_t;

  vec_t vecs[NV];

  initial begin
    int         e0;
    int         lat;
    logic [W:0] r;

    bus.in_valid  = 1'b0;
    bus.in_data_1 = '0;
    bus.in_data_2 = '0;

    vecs[0] = '{20'h00800, 3'd3, 20'h02000, 1'b0, 60};   // 2.0^3
    vecs[1] = '{20'h00600, 3'd2, 20'h00900, 1'b0, 40};   // 1.5^2
    vecs[2] = '{20'h00001, 3'd2, 20'h00000, 1'b0, 40};   // truncation to 0
    vecs[3] = '{20'h12345, 3'd0, 20'h00400, 1'b0, 0};    // n=0
    vecs[4] = '{20'h00000, 3'd4, 20'h00000, 1'b0, 80};   // x=0 full latency
    vecs[5] = '{20'h00600, 3'd7, 20'h04458, 1'b0, 140};  // 1.5^7, max n
    vecs[6] = '{20'h00C00, 3'd2, 20'h02400, 1'b0, 40};   // 3.0^2
`ifdef ROOT_INVERSE_POWER_SATURATE_EN
    vecs[7] = '{20'hFFC00, 3'd3, 20'hFFFFF, 1'b1, 40};   // 1023^3 saturates at step 2
`else
    vecs[7] = '{20'hFFC00, 3'd3, 20'hFFC00, 1'b1, 60};   // 1023^3 wraps
`endif
    for (int i = 8; i < NV; i++) begin
      vecs[i].x        = W'($urandom_range(0, 32'h01FFF));
      vecs[i].n        = EW'($urandom_range(0, 7));
      r                = model(vecs[i].x, int'(vecs[i].n), lat);
      vecs[i].exp_data = r[W-1:0];
      vecs[i].exp_ovf  = r[W];
      vecs[i].exp_lat  = lat;
    end

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_out_data",  32'(bus.out_data),  32'd0);
    check("reset_out_ovf",   32'(bus.out_ovf),   32'd0);
    check("reset_state",     32'(dbg_state),     32'(IDLE));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ---- table sweep ----
    for (int i = 0; i < NV; i++) begin
      send(vecs[i].x, vecs[i].n, 1 + (i % 2), e0);
      push_exp(vecs[i].exp_data, vecs[i].exp_ovf, e0 + vecs[i].exp_lat);
      wait_drain(200);
    end

    // ---- in_valid held 3 beats: last beat wins (0.5^2) ----
    @(negedge clk); bus.in_valid = 1'b1; bus.in_data_1 = 20'h00C00; bus.in_data_2 = 3'd5;
    @(negedge clk); bus.in_data_1 = 20'h00400; bus.in_data_2 = 3'd1;
    @(negedge clk); bus.in_data_1 = 20'h00200; bus.in_data_2 = 3'd2;
    @(negedge clk); bus.in_valid = 1'b0;
    e0 = cyc + 1;
    push_exp(20'h00100, 1'b0, e0 + 40);
    wait_drain(200);

    // ---- in_valid pulsed during MUL is ignored ----
    send(20'h00600, 3'd2, 1, e0);
    push_exp(20'h00900, 1'b0, e0 + 40);
    while (cyc < e0 + 9) @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_data_1 = 20'h00800;
    bus.in_data_2 = 3'd1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_drain(200);
    repeat (60) @(negedge clk);   // any second pulse is flagged by the monitor

    // ---- reset at E0+25 of an n=3 run: no pulse, then a clean run ----
    send(20'h00800, 3'd3, 1, e0);
    while (cyc < e0 + 24) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_state",     32'(dbg_state),     32'(IDLE));
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_out_data",  32'(bus.out_data),  32'd0);
    repeat (60) @(negedge clk);
    send(20'h00800, 3'd1, 1, e0);
    push_exp(20'h00800, 1'b0, e0 + 20);
    wait_drain(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
